// File: rtl/uart_tx_scheduler_if.sv
// Requester-side and uart_tx-side signals of the shared transmit scheduler.
interface uart_tx_scheduler_if #(
  parameter int NUM_REQ   = 4,
  parameter int DATA_BITS = 8
);
  logic [NUM_REQ-1:0]           req;
  logic [NUM_REQ*DATA_BITS-1:0] req_data;
  logic [2*NUM_REQ-1:0]         req_parity;
  logic [NUM_REQ-1:0]           ack;
  logic [NUM_REQ-1:0]           grant;
  logic                         tx_send;
  logic [DATA_BITS-1:0]         tx_data;
  logic [1:0]                   tx_parity;
  logic                         busy;

  modport master (
    output req, req_data, req_parity,
    input  ack, grant, tx_send, tx_data, tx_parity, busy
  );

  modport slave (
    input  req, req_data, req_parity,
    output ack, grant, tx_send, tx_data, tx_parity, busy
  );
endinterface

// File: rtl/uart_tx_scheduler.sv
// Round-robin arbiter sharing one uart_tx among NUM_REQ byte sources; it times
// each frame plus guard gap itself because uart_tx has no busy indication.
module uart_tx_scheduler #(
  parameter int NUM_REQ         = 4,
  parameter int DATA_BITS       = 8,
  parameter int CLOCKS_PER_BIT  = 434,
  parameter int GAP_CLOCKS      = 16,
  parameter int CLOCK_CTR_WIDTH = 32
) (
  input logic                clk,
  input logic                rst,
  uart_tx_scheduler_if.slave bus
);
  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  // Start + data + stop bits plus gap; a parity bit adds one more bit time.
  localparam logic [CLOCK_CTR_WIDTH-1:0] BASE_CLKS =
    CLOCK_CTR_WIDTH'((DATA_BITS + 2) * CLOCKS_PER_BIT + GAP_CLOCKS);
  localparam logic [CLOCK_CTR_WIDTH-1:0] PARITY_CLKS = CLOCK_CTR_WIDTH'(CLOCKS_PER_BIT);
  localparam logic [PTR_W-1:0]           LAST_IDX    = PTR_W'(NUM_REQ - 1);

  typedef enum logic {IDLE, FRAME} state_t;

  state_t                     state_reg, state_next;
  logic [PTR_W-1:0]           rr_ptr_reg, rr_ptr_next;
  logic [NUM_REQ-1:0]         grant_reg, grant_next;
  logic                       launch_reg, launch_next;
  logic [CLOCK_CTR_WIDTH-1:0] timer_reg, timer_next;
  logic [DATA_BITS-1:0]       tx_data_reg, tx_data_next;
  logic [1:0]                 tx_parity_reg, tx_parity_next;

  logic [DATA_BITS-1:0]       data_arr   [NUM_REQ];
  logic [1:0]                 parity_arr [NUM_REQ];
  logic                       found;
  logic [PTR_W-1:0]           win_idx;
  logic [PTR_W-1:0]           cand;
  logic [CLOCK_CTR_WIDTH-1:0] frame_clks;

  // Mode 3 is folded to "none" here so both framing and forwarding see 0.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
      assign data_arr[gi]   = bus.req_data[gi*DATA_BITS +: DATA_BITS];
      assign parity_arr[gi] = (bus.req_parity[2*gi +: 2] == 2'd3) ? 2'd0
                                                                 : bus.req_parity[2*gi +: 2];
    end
  endgenerate

  // First asserted request scanning upward from the slot after the last winner.
  always_comb begin
    found   = 1'b0;
    win_idx = rr_ptr_reg;
    cand    = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = PTR_W'((int'(rr_ptr_reg) + k) % NUM_REQ);
      if (!found && bus.req[cand]) begin
        found   = 1'b1;
        win_idx = cand;
      end
    end
  end

  assign frame_clks = BASE_CLKS + ((parity_arr[win_idx] != 2'd0) ? PARITY_CLKS
                                                                  : CLOCK_CTR_WIDTH'(0));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      rr_ptr_reg    <= LAST_IDX;
      grant_reg     <= '0;
      launch_reg    <= 1'b0;
      timer_reg     <= '0;
      tx_data_reg   <= '0;
      tx_parity_reg <= '0;
    end else begin
      state_reg     <= state_next;
      rr_ptr_reg    <= rr_ptr_next;
      grant_reg     <= grant_next;
      launch_reg    <= launch_next;
      timer_reg     <= timer_next;
      tx_data_reg   <= tx_data_next;
      tx_parity_reg <= tx_parity_next;
    end
  end

  // The timer counts down the remaining FRAME cycles; zero marks the last one.
  always_comb begin
    state_next     = state_reg;
    rr_ptr_next    = rr_ptr_reg;
    grant_next     = grant_reg;
    launch_next    = 1'b0;
    timer_next     = timer_reg;
    tx_data_next   = tx_data_reg;
    tx_parity_next = tx_parity_reg;
    case (state_reg)
      IDLE: begin
        if (found) begin
          state_next     = FRAME;
          rr_ptr_next    = win_idx;
          grant_next     = NUM_REQ'(1) << win_idx;
          launch_next    = 1'b1;
          timer_next     = frame_clks - CLOCK_CTR_WIDTH'(1);
          tx_data_next   = data_arr[win_idx];
          tx_parity_next = parity_arr[win_idx];
        end
      end
      FRAME: begin
        if (timer_reg == '0) begin
          state_next = IDLE;
          grant_next = '0;
        end else begin
          timer_next = timer_reg - CLOCK_CTR_WIDTH'(1);
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign bus.ack       = launch_reg ? grant_reg : '0;
  assign bus.grant     = grant_reg;
  assign bus.tx_send   = launch_reg;
  assign bus.tx_data   = tx_data_reg;
  assign bus.tx_parity = tx_parity_reg;
  assign bus.busy      = (state_reg == FRAME);
endmodule
